// File: rtl/vend_pkg.sv
// Shared types and widths for the vending controller slice.
// Optional feature macro used by vend_controller: VEND_TIMEOUT_EN.
package vend_pkg;

   localparam int SLOTS    = 4;
   localparam int SW       = $clog2(SLOTS);
   localparam int PRICE_W  = 4;
   localparam int QTY_W    = 4;
   localparam int CREDIT_W = 6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CREDIT,
      S_CHECK,
      S_DISPENSE,
      S_CHANGE
   } vend_state_t;

   typedef struct packed {
      logic [QTY_W-1:0]   qty;
      logic [PRICE_W-1:0] price;
   } slot_entry_t;

endpackage

// File: rtl/vend_slot_table.sv
// Slot price/quantity register file: one write port, two combinational read ports.
// The single write port is shared by configuration (IDLE only) and the
// post-CHECK quantity decrement, which can never occur in the same cycle.
module vend_slot_table import vend_pkg::*; (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_we,
   input  logic [SW-1:0]     i_wr_slot,
   input  slot_entry_t       i_wr_data,
   input  logic [SW-1:0]     i_rd_a_slot,
   output slot_entry_t       o_rd_a,
   input  logic [SW-1:0]     i_rd_b_slot,
   output slot_entry_t       o_rd_b
);

   slot_entry_t r_tab [SLOTS];

   // Table storage: cleared by reset, written one entry per edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SLOTS; i++) begin
            r_tab[i] <= '0;
         end
      end else if (i_we) begin
         r_tab[i_wr_slot] <= i_wr_data;
      end
   end

   assign o_rd_a = r_tab[i_rd_a_slot];
   assign o_rd_b = r_tab[i_rd_b_slot];

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: credit accumulation, select/check/dispense/change.
// Optional macro VEND_TIMEOUT_EN adds an inactivity auto-refund in CREDIT.
module vend_controller import vend_pkg::*; #(
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                coin_valid,
   input  logic [PRICE_W-1:0]  coin_val,
   input  logic                sel_valid,
   input  logic [SW-1:0]       sel_slot,
   input  logic                cancel,
   input  logic                cfg_we,
   input  logic [SW-1:0]       cfg_slot,
   input  logic [PRICE_W-1:0]  cfg_price,
   input  logic [QTY_W-1:0]    cfg_qty,
   input  logic [SW-1:0]       rd_slot,
   output logic [PRICE_W-1:0]  rd_price,
   output logic [QTY_W-1:0]    rd_qty,
   output logic                disp_req,
   output logic [SW-1:0]       disp_slot,
   input  logic                disp_ack,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change_val,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy,
   output logic                err_soldout,
   output logic                err_funds,
   output logic                coin_reject
);

   vend_state_t         r_state, w_state_nx;
   logic [CREDIT_W-1:0] r_credit, w_credit_nx;
   logic [SW-1:0]       r_sel, w_sel_nx;
   logic                r_coin_reject, w_coin_reject_nx;
   logic                r_err_soldout, w_err_soldout_nx;
   logic                r_err_funds, w_err_funds_nx;
   logic                r_change_valid, w_change_valid_nx;
   logic [CREDIT_W-1:0] r_change_val, w_change_val_nx;

   logic                w_tab_we;
   logic [SW-1:0]       w_tab_slot;
   slot_entry_t         w_tab_data;
   slot_entry_t         w_chk_entry;
   slot_entry_t         w_rd_entry;
   logic [CREDIT_W:0]   w_coin_sum;
   logic                w_coin_ok;
   logic                w_timeout;

   vend_slot_table u_table (
      .clk         (clk),
      .reset       (reset),
      .i_we        (w_tab_we),
      .i_wr_slot   (w_tab_slot),
      .i_wr_data   (w_tab_data),
      .i_rd_a_slot (r_sel),
      .o_rd_a      (w_chk_entry),
      .i_rd_b_slot (rd_slot),
      .o_rd_b      (w_rd_entry)
   );

   // Coin sum carries one extra bit so overflow is simply the top bit.
   assign w_coin_sum = {1'b0, r_credit} + (CREDIT_W+1)'(coin_val);
   assign w_coin_ok  = ~w_coin_sum[CREDIT_W];

`ifdef VEND_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] r_to_cnt;

   assign w_timeout = (r_state == S_CREDIT) && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

   // Inactivity counter: restarts on CREDIT entry and on any coin or selection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_to_cnt <= '0;
      end else if (((r_state != S_CREDIT) && (w_state_nx == S_CREDIT)) || coin_valid || sel_valid) begin
         r_to_cnt <= '0;
      end else if ((r_state == S_CREDIT) && !w_timeout) begin
         r_to_cnt <= r_to_cnt + TW'(1);
      end
   end
`else
   logic w_unused_timeout;
   // Timeout parameter has no effect when the refund timer is compiled out.
   assign w_unused_timeout = (TIMEOUT_CYC > 0);
   assign w_timeout        = 1'b0;
`endif

   // Next-state, credit, table-write and pulse decisions for the transaction FSM.
   always_comb begin
      w_state_nx        = r_state;
      w_credit_nx       = r_credit;
      w_sel_nx          = r_sel;
      w_coin_reject_nx  = 1'b0;
      w_err_soldout_nx  = 1'b0;
      w_err_funds_nx    = 1'b0;
      w_change_valid_nx = 1'b0;
      w_change_val_nx   = '0;
      w_tab_we          = 1'b0;
      w_tab_slot        = cfg_slot;
      w_tab_data        = '{qty: cfg_qty, price: cfg_price};

      unique case (r_state)
         S_IDLE, S_CREDIT: begin
            if (coin_valid) begin
               if (w_coin_ok) w_credit_nx = w_coin_sum[CREDIT_W-1:0];
               else           w_coin_reject_nx = 1'b1;
            end
            if ((r_state == S_IDLE) && cfg_we) w_tab_we = 1'b1;
            // Cancel beats selection; a same-cycle coin is already in w_credit_nx.
            if (cancel && (r_state == S_CREDIT)) begin
               w_state_nx = S_CHANGE;
            end else if (sel_valid) begin
               w_sel_nx   = sel_slot;
               w_state_nx = S_CHECK;
            end else if (coin_valid && w_coin_ok) begin
               w_state_nx = S_CREDIT;
            end else if (w_timeout && !coin_valid) begin
               w_state_nx = S_CHANGE;
            end
         end
         S_CHECK: begin
            w_coin_reject_nx = coin_valid;
            if (w_chk_entry.qty == '0) begin
               w_err_soldout_nx = 1'b1;
               w_state_nx       = (r_credit != '0) ? S_CREDIT : S_IDLE;
            end else if (r_credit < CREDIT_W'(w_chk_entry.price)) begin
               w_err_funds_nx = 1'b1;
               w_state_nx     = (r_credit != '0) ? S_CREDIT : S_IDLE;
            end else begin
               w_credit_nx = r_credit - CREDIT_W'(w_chk_entry.price);
               w_tab_we    = 1'b1;
               w_tab_slot  = r_sel;
               w_tab_data  = '{qty: w_chk_entry.qty - QTY_W'(1), price: w_chk_entry.price};
               w_state_nx  = S_DISPENSE;
            end
         end
         S_DISPENSE: begin
            w_coin_reject_nx = coin_valid;
            if (disp_ack) w_state_nx = S_CHANGE;
         end
         S_CHANGE: begin
            w_coin_reject_nx = coin_valid;
            if (r_credit != '0) begin
               w_change_valid_nx = 1'b1;
               w_change_val_nx   = r_credit;
            end
            w_credit_nx = '0;
            w_state_nx  = S_IDLE;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // State register and registered outputs; reset abandons any transaction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= S_IDLE;
         r_credit       <= '0;
         r_sel          <= '0;
         r_coin_reject  <= 1'b0;
         r_err_soldout  <= 1'b0;
         r_err_funds    <= 1'b0;
         r_change_valid <= 1'b0;
         r_change_val   <= '0;
      end else begin
         r_state        <= w_state_nx;
         r_credit       <= w_credit_nx;
         r_sel          <= w_sel_nx;
         r_coin_reject  <= w_coin_reject_nx;
         r_err_soldout  <= w_err_soldout_nx;
         r_err_funds    <= w_err_funds_nx;
         r_change_valid <= w_change_valid_nx;
         r_change_val   <= w_change_val_nx;
      end
   end

   assign rd_price     = w_rd_entry.price;
   assign rd_qty       = w_rd_entry.qty;
   assign disp_req     = (r_state == S_DISPENSE);
   assign disp_slot    = r_sel;
   assign change_valid = r_change_valid;
   assign change_val   = r_change_val;
   assign credit       = r_credit;
   assign busy         = (r_state != S_IDLE);
   assign err_soldout  = r_err_soldout;
   assign err_funds    = r_err_funds;
   assign coin_reject  = r_coin_reject;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus a randomized
// transaction loop predicted by a transaction-level model of credit and stock.
module tb_vend_controller;
   import vend_pkg::*;

   logic                clk = 1'b0;
   logic                reset;
   logic                coin_valid;
   logic [PRICE_W-1:0]  coin_val;
   logic                sel_valid;
   logic [SW-1:0]       sel_slot;
   logic                cancel;
   logic                cfg_we;
   logic [SW-1:0]       cfg_slot;
   logic [PRICE_W-1:0]  cfg_price;
   logic [QTY_W-1:0]    cfg_qty;
   logic [SW-1:0]       rd_slot;
   logic [PRICE_W-1:0]  rd_price;
   logic [QTY_W-1:0]    rd_qty;
   logic                disp_req;
   logic [SW-1:0]       disp_slot;
   logic                disp_ack;
   logic                change_valid;
   logic [CREDIT_W-1:0] change_val;
   logic [CREDIT_W-1:0] credit;
   logic                busy;
   logic                err_soldout;
   logic                err_funds;
   logic                coin_reject;

   int checks   = 0;
   int failures = 0;

   // Reference model: per-slot table, credit, and whether a customer session is open.
   int m_price [SLOTS];
   int m_qty   [SLOTS];
   int m_credit;
   bit m_active;

   localparam int MAX_CREDIT = (1 << CREDIT_W) - 1;

   always #5 clk = ~clk;

   vend_controller #(.TIMEOUT_CYC(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .coin_valid   (coin_valid),
      .coin_val     (coin_val),
      .sel_valid    (sel_valid),
      .sel_slot     (sel_slot),
      .cancel       (cancel),
      .cfg_we       (cfg_we),
      .cfg_slot     (cfg_slot),
      .cfg_price    (cfg_price),
      .cfg_qty      (cfg_qty),
      .rd_slot      (rd_slot),
      .rd_price     (rd_price),
      .rd_qty       (rd_qty),
      .disp_req     (disp_req),
      .disp_slot    (disp_slot),
      .disp_ack     (disp_ack),
      .change_valid (change_valid),
      .change_val   (change_val),
      .credit       (credit),
      .busy         (busy),
      .err_soldout  (err_soldout),
      .err_funds    (err_funds),
      .coin_reject  (coin_reject)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      for (int i = 0; i < SLOTS; i++) begin
         m_price[i] = 0;
         m_qty[i]   = 0;
      end
      m_credit = 0;
      m_active = 0;
   endtask

   task automatic do_cfg(input int s, input int p, input int q);
      cfg_we = 1'b1; cfg_slot = SW'(s); cfg_price = PRICE_W'(p); cfg_qty = QTY_W'(q);
      tick;
      cfg_we = 1'b0;
      if (!m_active) begin
         m_price[s] = p;
         m_qty[s]   = q;
      end
      rd_slot = SW'(s);
      #1;
      chk("cfg_rd_price", rd_price, m_price[s]);
      chk("cfg_rd_qty", rd_qty, m_qty[s]);
   endtask

   task automatic do_coin(input int v);
      bit rej;
      rej = (m_credit + v) > MAX_CREDIT;
      coin_valid = 1'b1; coin_val = PRICE_W'(v);
      tick;
      coin_valid = 1'b0;
      if (!rej) begin
         m_credit += v;
         m_active = 1;
      end
      chk("coin_reject", coin_reject, rej);
      chk("coin_credit", credit, m_credit);
      chk("coin_busy", busy, m_active);
   endtask

   task automatic finish_change;
      chk("change_valid", change_valid, (m_credit > 0));
      if (m_credit > 0) chk("change_val", change_val, m_credit);
      m_credit = 0;
      m_active = 0;
      chk("change_credit", credit, 0);
      chk("change_busy", busy, 0);
   endtask

   task automatic do_cancel;
      cancel = 1'b1;
      tick;
      cancel = 1'b0;
      if (!m_active) begin
         chk("cancel_idle_busy", busy, 0);
         chk("cancel_idle_change", change_valid, 0);
      end else begin
         chk("cancel_busy", busy, 1);
         tick;
         finish_change();
      end
   endtask

   // Selection, optionally with a same-cycle coin and a coin during dispense.
   task automatic do_select(input int s, input int coin_with, input bit coin_in_disp);
      bit rej;
      int d;
      rej = 0;
      sel_valid = 1'b1; sel_slot = SW'(s);
      if (coin_with >= 0) begin
         coin_valid = 1'b1; coin_val = PRICE_W'(coin_with);
      end
      tick;
      sel_valid = 1'b0; coin_valid = 1'b0;
      if (coin_with >= 0) begin
         rej = (m_credit + coin_with) > MAX_CREDIT;
         if (!rej) m_credit += coin_with;
         chk("sel_coin_reject", coin_reject, rej);
      end
      chk("sel_check_busy", busy, 1);
      chk("sel_check_noreq", disp_req, 0);
      tick;
      if (m_qty[s] == 0) begin
         chk("soldout_pulse", err_soldout, 1);
         chk("soldout_nofunds", err_funds, 0);
         chk("soldout_noreq", disp_req, 0);
         chk("soldout_credit", credit, m_credit);
         m_active = (m_credit > 0);
         chk("soldout_busy", busy, m_active);
      end else if (m_credit < m_price[s]) begin
         chk("funds_pulse", err_funds, 1);
         chk("funds_nosoldout", err_soldout, 0);
         chk("funds_noreq", disp_req, 0);
         chk("funds_credit", credit, m_credit);
         m_active = (m_credit > 0);
         chk("funds_busy", busy, m_active);
      end else begin
         m_credit -= m_price[s];
         m_qty[s]--;
         chk("disp_noerr", {err_soldout, err_funds}, 0);
         chk("disp_req", disp_req, 1);
         chk("disp_slot", disp_slot, s);
         chk("disp_credit", credit, m_credit);
         d = coin_in_disp ? $urandom_range(1, 3) : $urandom_range(0, 3);
         for (int i = 0; i < d; i++) begin
            if (coin_in_disp && i == 0) begin
               coin_valid = 1'b1; coin_val = PRICE_W'(1);
            end
            tick;
            if (coin_in_disp && i == 0) begin
               coin_valid = 1'b0;
               chk("disp_coin_reject", coin_reject, 1);
               chk("disp_coin_credit", credit, m_credit);
            end
            chk("disp_req_hold", disp_req, 1);
         end
         disp_ack = 1'b1;
         tick;
         disp_ack = 1'b0;
         chk("ack_req_drop", disp_req, 0);
         chk("ack_busy", busy, 1);
         tick;
         finish_change();
         rd_slot = SW'(s);
         #1;
         chk("disp_rd_qty", rd_qty, m_qty[s]);
      end
   endtask

   initial begin
      bit seen;
      coin_valid = 0; coin_val = 0; sel_valid = 0; sel_slot = 0; cancel = 0;
      cfg_we = 0; cfg_slot = 0; cfg_price = 0; cfg_qty = 0; rd_slot = 0; disp_ack = 0;
      model_reset();
      reset = 1'b0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_credit", credit, 0);
      chk("rst_outs", {disp_req, change_valid, err_soldout, err_funds, coin_reject}, 0);
      for (int i = 0; i < SLOTS; i++) begin
         rd_slot = SW'(i);
         #1;
         chk("rst_rd", {rd_price, rd_qty}, 0);
      end
      tick;
      reset = 1'b1;
      tick;

      // Configure, then buy with change.
      do_cfg(1, 5, 2);
      chk("cfg_busy", busy, 0);
      do_coin(3);
      do_coin(4);
      do_select(1, -1, 0);

      // Sold out keeps credit; cancel refunds it.
      do_cfg(2, 4, 0);
      do_coin(6);
      do_select(2, -1, 0);
      do_cancel();

      // Insufficient funds.
      do_cfg(3, 9, 3);
      do_coin(5);
      do_select(3, -1, 0);
      do_cancel();

      // Coin and selection together: check sees the new credit.
      do_cfg(0, 7, 3);
      do_coin(4);
      do_select(0, 3, 0);

      // Selection and cancel together: cancel wins.
      do_coin(5);
      sel_valid = 1'b1; sel_slot = 2'd0; cancel = 1'b1;
      tick;
      sel_valid = 1'b0; cancel = 1'b0;
      chk("selcancel_noreq", disp_req, 0);
      tick;
      finish_change();

      // Coin and cancel together: full credit refunded.
      do_coin(2);
      coin_valid = 1'b1; coin_val = 4'd3; cancel = 1'b1;
      tick;
      coin_valid = 1'b0; cancel = 1'b0;
      m_credit += 3;
      tick;
      finish_change();

      // Cancel while idle does nothing.
      do_cancel();

      // Overflow reject at 60 + 8, then coin rejected during dispense.
      repeat (4) do_coin(15);
      do_coin(8);
      do_select(1, -1, 1);

      // Randomized transactions.
      for (int it = 0; it < 80; it++) begin
         int op;
         op = $urandom_range(0, 7);
         if (op <= 3) begin
            do_coin($urandom_range(0, 15));
         end else if (op <= 5) begin
            do_select($urandom_range(0, SLOTS - 1),
                      ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : -1,
                      1'($urandom_range(0, 1)));
         end else if (op == 6) begin
            do_cancel();
         end else begin
            do_cfg($urandom_range(0, SLOTS - 1), $urandom_range(1, 15), $urandom_range(0, 3));
            if (m_active) do_coin(0);
         end
      end
      if (m_active) do_cancel();

      // Inactivity behaviour in CREDIT.
      do_coin(2);
`ifdef VEND_TIMEOUT_EN
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (change_valid === 1'b1) begin
            seen = 1;
            break;
         end
      end
      chk("timeout_refund_seen", seen, 1);
      if (seen) chk("timeout_change_val", change_val, 2);
      m_credit = 0;
      m_active = 0;
      chk("timeout_credit", credit, 0);
      chk("timeout_busy", busy, 0);
`else
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (change_valid === 1'b1) seen = 1;
      end
      chk("hold_no_refund", seen, 0);
      chk("hold_credit", credit, 2);
      chk("hold_busy", busy, 1);
      do_cancel();
`endif

      // Reset in the middle of a dispense abandons the transaction.
      do_cfg(1, 3, 2);
      do_coin(5);
      sel_valid = 1'b1; sel_slot = 2'd1;
      tick;
      sel_valid = 1'b0;
      tick;
      chk("prerst_disp_req", disp_req, 1);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      rd_slot = 2'd1;
      #1;
      chk("midrst_disp_req", disp_req, 0);
      chk("midrst_credit", credit, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_rd_qty", rd_qty, 0);
      tick;
      reset = 1'b1;
      tick;
      chk("postrst_change", change_valid, 0);
      chk("postrst_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
